// File: rtl/weight_tile_loader_pkg.sv
// Shared constants, FSM encoding and tile addressing for the weight tile loader.
// The element-to-slot mapping lives here so the buffer and any checker agree on it.
package weight_tile_loader_pkg;

    localparam int TILE_EDGE  = 4;
    localparam int TILE_ELEMS = TILE_EDGE * TILE_EDGE;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FULL  = 2'd3
    } state_e;

    // Arrival order n walks rows fastest: r = n mod 4, c = n div 4, slot = r*4 + c.
    function automatic logic [CNT_W-1:0] tile_slot(input logic [CNT_W-1:0] n);
        return {n[1:0], n[3:2]};
    endfunction

endpackage

// File: rtl/weight_tile_loader_counter.sv
// Free-running wrap-around counter with enable; shared by the issue and capture paths.
module weight_tile_loader_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count register: clears on reset, advances and wraps naturally when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/weight_tile_loader.sv
// Loads one TILE x TILE weight tile from a 1-cycle-latency memory into a register
// buffer and presents it to the consumer with a valid/ready handshake.
module weight_tile_loader
    import weight_tile_loader_pkg::*;
#(
    parameter int DW   = 8,
    parameter int TILE = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      gen_en,
    output logic                      mem_rd_en,
    input  logic [DW-1:0]             mem_rdata,
    output logic [TILE*TILE*DW-1:0]   tile_data,
    output logic                      tile_valid,
    input  logic                      tile_ready,
    output logic                      busy
);

    state_e             state_r;
    state_e             state_s;
    logic [CNT_W-1:0]   issue_cnt_s;
    logic [CNT_W-1:0]   cap_idx_s;
    logic               issue_last_s;
    logic               capture_r;
    logic [DW-1:0]      tile_buf_r [TILE_ELEMS];

    weight_tile_loader_counter #(.W(CNT_W)) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (mem_rd_en),
        .count (issue_cnt_s)
    );

    // Read data is valid the cycle after each strobe, so the capture index follows a delayed strobe.
    weight_tile_loader_counter #(.W(CNT_W)) u_cap_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (capture_r),
        .count (cap_idx_s)
    );

    assign issue_last_s = (issue_cnt_s == 4'd15);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issue_last_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                state_s = ST_FULL;
            end
            ST_FULL: begin
                if (tile_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode; gen_en is the only Mealy output and is masked while reset is held.
    always_comb begin
        gen_en     = 1'b0;
        mem_rd_en  = 1'b0;
        tile_valid = 1'b0;
        busy       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                gen_en = start & ~rst;
            end
            ST_ISSUE: begin
                mem_rd_en = 1'b1;
                busy      = 1'b1;
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            ST_FULL: begin
                tile_valid = 1'b1;
                busy       = 1'b1;
            end
            default: begin
                gen_en = 1'b0;
            end
        endcase
    end

    // Delayed read strobe marking the cycle in which mem_rdata is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capture_r <= 1'b0;
        end else begin
            capture_r <= mem_rd_en;
        end
    end

    // Tile buffer: cleared on reset, written only on capture cycles, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TILE_ELEMS; i++) begin
                tile_buf_r[i] <= {DW{1'b0}};
            end
        end else if (capture_r) begin
            tile_buf_r[tile_slot(cap_idx_s)] <= mem_rdata;
        end
    end

    // Flatten the buffer into the packed output bus.
    always_comb begin
        tile_data = {(TILE*TILE*DW){1'b0}};
        for (int i = 0; i < TILE_ELEMS; i++) begin
            tile_data[i*DW +: DW] = tile_buf_r[i];
        end
    end

endmodule

// File: tb/tb_weight_tile_loader.sv
// Directed bench for weight_tile_loader: table-driven basic load plus hand-written
// sequences for backpressure, start-while-busy, reset mid-load and back-to-back tiles.
module tb_weight_tile_loader;

    localparam int DW = 8;
    localparam int TILE = 4;
    localparam int TW = TILE * TILE * DW;

    logic          clk;
    logic          rst;
    logic          start;
    logic          gen_en;
    logic          mem_rd_en;
    logic [DW-1:0] mem_rdata;
    logic [TW-1:0] tile_data;
    logic          tile_valid;
    logic          tile_ready;
    logic          busy;

    logic [7:0]    base;
    logic [3:0]    rd_pos;
    int            checks;
    int            errors;
    int            gen_cnt;
    int            rd_cnt;
    logic [TW-1:0] snap;

    typedef struct {
        logic start;
        logic rdy;
        logic gen;
        logic rd;
        logic bsy;
        logic vld;
    } vec_t;

    vec_t tbl [20];

    weight_tile_loader #(.DW(DW), .TILE(TILE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .gen_en     (gen_en),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .tile_data  (tile_data),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory model: word at sequence position n is base + n.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pos    <= 4'd0;
            mem_rdata <= 8'h00;
        end else if (mem_rd_en) begin
            mem_rdata <= base + {4'd0, rd_pos};
            rd_pos    <= rd_pos + 4'd1;
        end
    end

    function automatic logic [7:0] elem(input logic [TW-1:0] td, input int r, input int c);
        return td[(r*TILE + c)*DW +: DW];
    endfunction

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic rdy);
        @(posedge clk);
        #1;
        start = s;
        tile_ready = rdy;
        @(negedge clk);
        if (gen_en) gen_cnt++;
        if (mem_rd_en) rd_cnt++;
    endtask

    // Checks every element: tile[r][c] holds the word at sequence position c*4 + r.
    task automatic chk_tile(input string name, input logic [7:0] b);
        for (int r = 0; r < TILE; r++) begin
            for (int c = 0; c < TILE; c++) begin
                chk($sformatf("%s_r%0d_c%0d", name, r, c),
                    {{(TW-8){1'b0}}, elem(tile_data, r, c)},
                    {{(TW-8){1'b0}}, b + 8'(c*4 + r)});
            end
        end
    endtask

    // Full load with tile_ready held high; ends in the handshake cycle.
    task automatic run_load(input string name, input logic [7:0] b);
        base = b;
        gen_cnt = 0;
        rd_cnt = 0;
        step(1'b1, 1'b1);
        chk({name, "_gen"}, {{(TW-1){1'b0}}, gen_en}, {{(TW-1){1'b0}}, 1'b1});
        for (int k = 1; k <= 18; k++) step(1'b0, 1'b1);
        chk({name, "_valid"}, {{(TW-1){1'b0}}, tile_valid}, {{(TW-1){1'b0}}, 1'b1});
        chk({name, "_gen_cnt"}, TW'(gen_cnt), TW'(1));
        chk({name, "_rd_cnt"}, TW'(rd_cnt), TW'(16));
        chk_tile(name, b);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        gen_cnt = 0;
        rd_cnt = 0;
        base = 8'h10;
        start = 1'b0;
        tile_ready = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tbl[i].start = (i == 0);
            tbl[i].rdy   = 1'b1;
            tbl[i].gen   = (i == 0);
            tbl[i].rd    = (i >= 1) && (i <= 16);
            tbl[i].bsy   = (i >= 1) && (i <= 18);
            tbl[i].vld   = (i == 18);
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_gen_en", {{(TW-1){1'b0}}, gen_en}, '0);
        chk("rst_mem_rd_en", {{(TW-1){1'b0}}, mem_rd_en}, '0);
        chk("rst_tile_valid", {{(TW-1){1'b0}}, tile_valid}, '0);
        chk("rst_busy", {{(TW-1){1'b0}}, busy}, '0);
        chk("rst_tile_data", tile_data, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic load, cycle-by-cycle against the table
        base = 8'h10;
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].start, tbl[i].rdy);
            chk($sformatf("basic_gen_c%0d", i), {{(TW-1){1'b0}}, gen_en}, {{(TW-1){1'b0}}, tbl[i].gen});
            chk($sformatf("basic_rd_c%0d", i), {{(TW-1){1'b0}}, mem_rd_en}, {{(TW-1){1'b0}}, tbl[i].rd});
            chk($sformatf("basic_busy_c%0d", i), {{(TW-1){1'b0}}, busy}, {{(TW-1){1'b0}}, tbl[i].bsy});
            chk($sformatf("basic_valid_c%0d", i), {{(TW-1){1'b0}}, tile_valid}, {{(TW-1){1'b0}}, tbl[i].vld});
        end
        chk("basic_t10", {{(TW-8){1'b0}}, elem(tile_data, 1, 0)}, {{(TW-8){1'b0}}, 8'h11});
        chk("basic_t01", {{(TW-8){1'b0}}, elem(tile_data, 0, 1)}, {{(TW-8){1'b0}}, 8'h14});
        chk("basic_t33", {{(TW-8){1'b0}}, elem(tile_data, 3, 3)}, {{(TW-8){1'b0}}, 8'h1F});
        chk_tile("basic_retain", 8'h10);

        // Backpressure: tile_ready low for 10 cycles after tile_valid
        base = 8'h40;
        step(1'b1, 1'b0);
        for (int k = 1; k <= 18; k++) step(1'b0, 1'b0);
        chk("bp_valid_first", {{(TW-1){1'b0}}, tile_valid}, {{(TW-1){1'b0}}, 1'b1});
        snap = tile_data;
        chk("bp_t21", {{(TW-8){1'b0}}, elem(tile_data, 2, 1)}, {{(TW-8){1'b0}}, 8'h46});
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0);
            chk($sformatf("bp_valid_%0d", k), {{(TW-1){1'b0}}, tile_valid}, {{(TW-1){1'b0}}, 1'b1});
            chk($sformatf("bp_data_%0d", k), tile_data, snap);
        end
        step(1'b1, 1'b1);
        chk("bp_hs_valid", {{(TW-1){1'b0}}, tile_valid}, {{(TW-1){1'b0}}, 1'b1});
        chk("bp_hs_no_gen", {{(TW-1){1'b0}}, gen_en}, '0);
        step(1'b0, 1'b0);
        chk("bp_idle_valid", {{(TW-1){1'b0}}, tile_valid}, '0);
        chk("bp_idle_busy", {{(TW-1){1'b0}}, busy}, '0);
        chk("bp_idle_data", tile_data, snap);

        // Start while busy: extra pulses at cycles 5 and 17 are ignored
        base = 8'h60;
        gen_cnt = 0;
        rd_cnt = 0;
        for (int k = 0; k < 20; k++) step((k == 0) || (k == 5) || (k == 17), 1'b1);
        chk("sb_gen_cnt", TW'(gen_cnt), TW'(1));
        chk("sb_rd_cnt", TW'(rd_cnt), TW'(16));
        chk("sb_busy_end", {{(TW-1){1'b0}}, busy}, '0);
        chk_tile("sb", 8'h60);

        // Reset mid-load at cycle 8
        base = 8'h70;
        step(1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) step(1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mr_gen_en", {{(TW-1){1'b0}}, gen_en}, '0);
        chk("mr_mem_rd_en", {{(TW-1){1'b0}}, mem_rd_en}, '0);
        chk("mr_tile_valid", {{(TW-1){1'b0}}, tile_valid}, '0);
        chk("mr_busy", {{(TW-1){1'b0}}, busy}, '0);
        chk("mr_tile_data", tile_data, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        gen_cnt = 0;
        rd_cnt = 0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("mr_post_gen", TW'(gen_cnt), TW'(0));
        chk("mr_post_busy", {{(TW-1){1'b0}}, busy}, '0);
        run_load("mr_reload", 8'h80);
        step(1'b0, 1'b0);

        // Back-to-back tiles: second start the cycle after the handshake
        run_load("b2b_first", 8'h10);
        run_load("b2b_second", 8'h20);
        chk("b2b_t00", {{(TW-8){1'b0}}, elem(tile_data, 0, 0)}, {{(TW-8){1'b0}}, 8'h20});
        step(1'b0, 1'b0);
        chk("b2b_idle_busy", {{(TW-1){1'b0}}, busy}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
